// File: rtl/inst_sram_slave.sv
// Single-port instruction SRAM responder for the fetch-side inst_sram interface:
// one-cycle read-first reads, byte-lane writes, sticky access-error capture and a saturating read counter.
module inst_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        sram_err,
  output logic [31:0] sram_err_addr,
  output logic [31:0] sram_rd_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem_r [DEPTH];
  logic [31:0]           rdata_r;
  logic                  err_r;
  logic [31:0]           err_addr_r;
  logic [31:0]           rd_count_r;

  logic [31:0]           offset_s;
  logic [ADDR_WIDTH-1:0] index_s;
  logic                  in_range_s;
  logic                  aligned_s;
  logic                  legal_s;
  logic                  illegal_s;
  logic                  is_write_s;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // Address decode; offsets below the base wrap high and fall out of range
  always_comb begin
    offset_s   = inst_sram_addr - BASE_ADDR;
    index_s    = offset_s[ADDR_WIDTH+1:2];
    in_range_s = ((offset_s >> (ADDR_WIDTH + 2)) == 32'd0);
    aligned_s  = (offset_s[1:0] == 2'b00);
    legal_s    = inst_sram_en && aligned_s && in_range_s;
    illegal_s  = inst_sram_en && !(aligned_s && in_range_s);
    is_write_s = (inst_sram_we != 4'h0);
  end

  // Word storage; never reset, and writes are blocked while reset is asserted
  always_ff @(posedge clk) begin
    if (rst && legal_s && is_write_s) begin
      mem_r[index_s] <= merge_lanes(mem_r[index_s], inst_sram_wdata, inst_sram_we);
    end
  end

  // Read data register: read-first, zero on an illegal access, holds when idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_r <= 32'h0;
    end else if (legal_s) begin
      rdata_r <= mem_r[index_s];
    end else if (illegal_s) begin
      rdata_r <= 32'h0;
    end
  end

  // Sticky error flag with first-error address capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_r      <= 1'b0;
      err_addr_r <= 32'h0;
    end else if (illegal_s) begin
      err_r <= 1'b1;
      if (!err_r) begin
        err_addr_r <= inst_sram_addr;
      end
    end
  end

  // Saturating count of legal read-only accesses
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count_r <= 32'h0;
    end else if (legal_s && !is_write_s && (rd_count_r != 32'hFFFFFFFF)) begin
      rd_count_r <= rd_count_r + 32'd1;
    end
  end

  assign inst_sram_rdata = rdata_r;
  assign sram_err        = err_r;
  assign sram_err_addr   = err_addr_r;
  assign sram_rd_count   = rd_count_r;

endmodule
